// File: rtl/soil_dac_pkg.sv
// Shared types and constant helpers for the soil PWM DAC output stage.
package soil_dac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dac_state_t;

  // Millivolts per LSB, truncated, matching the ADC step convention.
  function automatic int unsigned step_size(input int unsigned resolution,
                                            input int unsigned vref_mv);
    return vref_mv / (32'd1 << resolution);
  endfunction

  // Prescale counter width; never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned prescale);
    return (prescale > 32'd1) ? int'($clog2(prescale)) : 32'd1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescale counter: emits a one-cycle tick every PRESCALE enabled clocks.
module pwm_tick_gen
  import soil_dac_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = presc_width(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soil_pwm_dac.sv
// PWM DAC: double-buffered code intake, period-aligned code updates and
// a millivolt readback of the code currently on the output.
module soil_pwm_dac
  import soil_dac_pkg::*;
#(
  parameter int unsigned RESOLUTION = 10,
  parameter int unsigned VREF_MV    = 5000,
  parameter int unsigned PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dac_enable,
  input  logic [RESOLUTION-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic [RESOLUTION-1:0] active_code,
  output logic [15:0]           voltage_mv
);

  localparam int unsigned STEP = step_size(RESOLUTION, VREF_MV);
  localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

  dac_state_t            state_q, state_d;
  logic [RESOLUTION-1:0] period_q, period_d;
  logic [RESOLUTION-1:0] pending_q, pending_d;
  logic [RESOLUTION-1:0] active_d;
  logic                  pending_vld_q, pending_vld_d;
  logic                  pwm_d, start_d, ready_d;
  logic [15:0]           voltage_d;
  logic                  run_c, tick_c, accept_c, boundary_c;

  assign run_c     = (state_q == RUN) && dac_enable;
  assign accept_c  = code_valid && code_ready;
  assign voltage_d = 16'(active_code * STEP);

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (run_c),
    .clr    (!run_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    active_d      = active_code;
    pwm_d         = 1'b0;
    start_d       = 1'b0;
    boundary_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        period_d = '0;
        if (dac_enable) begin
          state_d    = RUN;
          boundary_c = 1'b1;
        end
      end
      RUN: begin
        // Disable beats a coincident boundary: no reload, no start pulse.
        if (!dac_enable) begin
          state_d  = IDLE;
          period_d = '0;
        end else begin
          pwm_d = (period_q < active_code);
          if (tick_c) begin
            period_d   = period_q + 1'b1;
            boundary_c = (period_q == CNT_MAX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending drains first; an empty buffer lets a same-cycle code go straight in.
    if (boundary_c) begin
      start_d = 1'b1;
      if (pending_vld_q) begin
        active_d      = pending_q;
        pending_vld_d = 1'b0;
      end else if (accept_c) begin
        active_d = code_in;
      end
    end else if (accept_c) begin
      pending_d     = code_in;
      pending_vld_d = 1'b1;
    end

    ready_d = !pending_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      period_q      <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      active_code   <= '0;
      pwm_out       <= 1'b0;
      period_start  <= 1'b0;
      voltage_mv    <= '0;
      code_ready    <= 1'b1;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      active_code   <= active_d;
      pwm_out       <= pwm_d;
      period_start  <= start_d;
      voltage_mv    <= voltage_d;
      code_ready    <= ready_d;
    end
  end

endmodule

// File: tb/tb_soil_pwm_dac.sv
// Scoreboard bench: per-period duty, length, code and mV for two DAC configurations.
module tb_soil_pwm_dac;

  typedef struct {
    int code;
    int high;
    int len;
    int mv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dac_enable, code_valid, code_ready, pwm_out, period_start;
  logic [9:0]  code_in, active_code;
  logic [15:0] voltage_mv;
  logic        b_en, b_valid, b_ready, b_pwm, b_start;
  logic [3:0]  b_code, b_active;
  logic [15:0] b_mv;

  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int a_on = 0, a_len = 0, a_high = 0, a_code = 0;
  int b_on = 0, b_len = 0, b_high = 0, b_code_cap = 0;

  always #5 clk = ~clk;

  soil_pwm_dac #(.RESOLUTION(10), .VREF_MV(5000), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .dac_enable(dac_enable), .code_in(code_in),
    .code_valid(code_valid), .code_ready(code_ready), .pwm_out(pwm_out),
    .period_start(period_start), .active_code(active_code), .voltage_mv(voltage_mv)
  );

  soil_pwm_dac #(.RESOLUTION(4), .VREF_MV(5000), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .dac_enable(b_en), .code_in(b_code),
    .code_valid(b_valid), .code_ready(b_ready), .pwm_out(b_pwm),
    .period_start(b_start), .active_code(b_active), .voltage_mv(b_mv)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor A: a period spans period_start to the next one; pwm lags by a cycle,
  // and voltage_mv still shows the finished period's code on the closing cycle.
  always @(posedge clk) begin
    #1;
    if (reset || !dac_enable) begin
      a_on = 0;
    end else begin
      if (a_on != 0) begin
        a_len++;
        a_high += int'(pwm_out);
      end
      if (period_start) begin
        if (a_on != 0 && qa.size() > 0) begin
          ea = qa.pop_front();
          chk("a_code", a_code, ea.code);
          chk("a_high", a_high, ea.high);
          chk("a_len", a_len, ea.len);
          chk("a_mv", int'(voltage_mv), ea.mv);
        end
        a_on = 1;
        a_len = 0;
        a_high = 0;
        a_code = int'(active_code);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset || !b_en) begin
      b_on = 0;
    end else begin
      if (b_on != 0) begin
        b_len++;
        b_high += int'(b_pwm);
      end
      if (b_start) begin
        if (b_on != 0 && qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_code", b_code_cap, eb.code);
          chk("b_high", b_high, eb.high);
          chk("b_len", b_len, eb.len);
          chk("b_mv", int'(b_mv), eb.mv);
        end
        b_on = 1;
        b_len = 0;
        b_high = 0;
        b_code_cap = int'(b_active);
      end
    end
  end

  task automatic send_a(input int c);
    int ok = 0;
    code_valid = 1'b1;
    code_in = 10'(c);
    for (int i = 0; i < 3000 && ok == 0; i++) begin
      ok = int'(code_ready);
      @(negedge clk);
    end
    code_valid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_start();
    int seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    chk("period_start_seen", seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dac_enable = 1'b0; code_valid = 1'b0; code_in = '0;
    b_en = 1'b0; b_valid = 1'b0; b_code = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(code_ready), 1);
    chk("rst_b_ready", int'(b_ready), 1);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_start", int'(period_start), 0);
    chk("rst_active", int'(active_code), 0);
    chk("rst_mv", int'(voltage_mv), 0);
    reset = 1'b0;

    // Second instance: RES=4, PRESCALE=4, code 5 -> 64-cycle period, 20 high, 5*312 mV.
    b_valid = 1'b1; b_code = 4'd5;
    @(negedge clk);
    b_valid = 1'b0; b_en = 1'b1;
    repeat (3) qb.push_back(exp_t'{5, 20, 64, 1560});

    qa.push_back(exp_t'{256, 256, 1024, 1024});
    send_a(256);
    chk("idle_active_hold", int'(active_code), 0);
    dac_enable = 1'b1;
    @(negedge clk);
    chk("en_start", int'(period_start), 1);
    chk("en_active", int'(active_code), 256);

    qa.push_back(exp_t'{0, 0, 1024, 0});
    send_a(0);
    wait_start();
    qa.push_back(exp_t'{1023, 1023, 1024, 4092});
    send_a(1023);
    wait_start();
    repeat (400) @(negedge clk);

    qa.push_back(exp_t'{100, 100, 1024, 400});
    send_a(100);
    chk("b2b_ready_low", int'(code_ready), 0);
    chk("b2b_hold_active", int'(active_code), 1023);
    qa.push_back(exp_t'{200, 200, 1024, 800});
    send_a(200);
    chk("b2b_active", int'(active_code), 100);
    qa.push_back(exp_t'{777, 777, 1024, 3108});
    send_a(777);
    wait_start();
    wait_start();

    // Disable at counter 300 while pwm is high; pending 55 survives the pause.
    send_a(55);
    repeat (299) @(negedge clk);
    chk("pre_dis_pwm", int'(pwm_out), 1);
    dac_enable = 1'b0;
    @(negedge clk);
    chk("dis_pwm", int'(pwm_out), 0);
    repeat (5) @(negedge clk);
    chk("idle_start", int'(period_start), 0);
    chk("idle_pwm", int'(pwm_out), 0);
    qa.push_back(exp_t'{55, 55, 1024, 220});
    dac_enable = 1'b1;
    @(negedge clk);
    chk("reen_start", int'(period_start), 1);
    chk("reen_active", int'(active_code), 55);
    wait_start();

    // Reset mid-period with 50 pending: everything clears, pending is lost.
    send_a(50);
    repeat (100) @(negedge clk);
    reset = 1'b1; dac_enable = 1'b0;
    @(negedge clk);
    chk("mid_rst_pwm", int'(pwm_out), 0);
    chk("mid_rst_active", int'(active_code), 0);
    chk("mid_rst_mv", int'(voltage_mv), 0);
    chk("mid_rst_ready", int'(code_ready), 1);
    chk("mid_rst_start", int'(period_start), 0);
    reset = 1'b0;
    @(negedge clk);
    qa.push_back(exp_t'{0, 0, 1024, 0});
    dac_enable = 1'b1;
    @(negedge clk);
    chk("post_rst_start", int'(period_start), 1);
    chk("post_rst_active", int'(active_code), 0);

    for (int i = 0; i < 3000 && qa.size() > 0; i++) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
